// File: rtl/mul_issue_ctrl_if.sv
// Handshake and multiplier-side signal bundle for mul_issue_ctrl.
// The slave view belongs to the controller; the master view belongs to its environment.
interface mul_issue_ctrl_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_mlier;
    logic [31:0]      in_mcand;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_prodt;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;
    logic [31:0]      mul_mlier;
    logic [31:0]      mul_mcand;
    logic             mul_start;
    logic [63:0]      mul_prodt;
    logic             mul_valid;
    logic             busy;

    modport slave (
        input  in_valid, in_mlier, in_mcand, in_tag, out_ready, mul_prodt, mul_valid,
        output in_ready, out_valid, out_prodt, out_tag, out_err,
               mul_mlier, mul_mcand, mul_start, busy
    );

    modport master (
        output in_valid, in_mlier, in_mcand, in_tag, out_ready, mul_prodt, mul_valid,
        input  in_ready, out_valid, out_prodt, out_tag, out_err,
               mul_mlier, mul_mcand, mul_start, busy
    );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Issue controller for the multi_vl multiplier: operand FIFO, level-held start
// sequencing with a watchdog, and a held result toward a valid/ready consumer.
module mul_issue_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 40,
    parameter int TAG_W   = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    mul_issue_ctrl_if.slave  bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;
    localparam int EW   = 64 + TAG_W;
    localparam int WD_W = $clog2(TIMEOUT) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    state_e           state_q;
    logic [WD_W-1:0]  wdog_q;
    logic [31:0]      mul_mlier_q;
    logic [31:0]      mul_mcand_q;
    logic             mul_start_q;
    logic [TAG_W-1:0] tag_q;
    logic             out_valid_q;
    logic [63:0]      out_prodt_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             out_err_q;

    logic             full_s;
    logic             empty_s;
    logic             push_s;
    logic             pop_s;
    logic [EW-1:0]    head_s;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full_s  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign push_s  = bus.in_valid && !full_s;
    assign pop_s   = (state_q == ST_IDLE) && !empty_s;
    assign head_s  = mem_q[rd_ptr_q[AW-1:0]];

    assign bus.in_ready  = !full_s;
    assign bus.busy      = !empty_s || (state_q != ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_prodt = out_prodt_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.out_err   = out_err_q;
    assign bus.mul_mlier = mul_mlier_q;
    assign bus.mul_mcand = mul_mcand_q;
    assign bus.mul_start = mul_start_q;

    // Operand FIFO storage and pointers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= {bus.in_mlier, bus.in_mcand, bus.in_tag};
                wr_ptr_q                <= wr_ptr_q + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // Issue sequencing, watchdog and result holding register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            wdog_q      <= '0;
            mul_mlier_q <= 32'd0;
            mul_mcand_q <= 32'd0;
            mul_start_q <= 1'b0;
            tag_q       <= '0;
            out_valid_q <= 1'b0;
            out_prodt_q <= 64'd0;
            out_tag_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pop_s) begin
                        mul_mlier_q <= head_s[EW-1:TAG_W+32];
                        mul_mcand_q <= head_s[TAG_W+31:TAG_W];
                        tag_q       <= head_s[TAG_W-1:0];
                        mul_start_q <= 1'b1;
                        wdog_q      <= '0;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // A product arriving in the last watchdog cycle still wins.
                    if (bus.mul_valid) begin
                        out_prodt_q <= bus.mul_prodt;
                        out_err_q   <= 1'b0;
                        out_tag_q   <= tag_q;
                        out_valid_q <= 1'b1;
                        mul_start_q <= 1'b0;
                        state_q     <= ST_HOLD;
                    end else if (wdog_q == WD_LAST) begin
                        out_prodt_q <= 64'd0;
                        out_err_q   <= 1'b1;
                        out_tag_q   <= tag_q;
                        out_valid_q <= 1'b1;
                        mul_start_q <= 1'b0;
                        state_q     <= ST_HOLD;
                    end else begin
                        wdog_q <= wdog_q + WD_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    mul_start_q <= 1'b0;
                    out_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: a behavioural multi_vl stub with per-op latency,
// a result scoreboard, directed vectors and randomized traffic.
module tb_mul_issue_ctrl;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 40;
    localparam int TAG_W   = 4;

    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    mul_issue_ctrl_if #(.TAG_W(TAG_W)) bus ();

    mul_issue_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .TAG_W(TAG_W)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [63:0]      prod;
        logic [TAG_W-1:0] tag;
        logic             err;
    } exp_t;

    typedef struct {
        logic [31:0]      mlier;
        logic [31:0]      mcand;
        logic [TAG_W-1:0] tag;
        int               lat;
        logic [63:0]      prod;
        logic             err;
    } vec_t;

    exp_t exp_q[$];
    int   lat_q[$];
    vec_t vecs[10];

    int n_cmp  = 0;
    int n_fail = 0;
    bit rand_ready = 1'b0;
    bit spurious   = 1'b0;
    int drv_lat    = 1;
    bit last_in_acc, last_out_acc;
    logic [63:0]      last_prodt;
    logic [TAG_W-1:0] last_tag;
    logic             last_err;
    int st_cnt = 0, cur_lat = 0, start_len = 0, low_cnt = 0;
    bit st_done = 1'b0, have_prev = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        return 64'(longint'($signed(a)) * longint'($signed(b)));
    endfunction

    // One clock: negedge sampling (scoreboard + multiplier stub), then inputs after posedge.
    task automatic tick();
        exp_t e;
        @(negedge clock);
        last_in_acc  = 1'b0;
        last_out_acc = 1'b0;
        if (!reset_n) begin
            exp_q.delete();
            lat_q.delete();
            st_cnt = 0; st_done = 1'b0; have_prev = 1'b0; low_cnt = 0;
            bus.mul_valid = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                last_in_acc = 1'b1;
                e.prod = (drv_lat == 0) ? 64'd0 : smul(bus.in_mlier, bus.in_mcand);
                e.tag  = bus.in_tag;
                e.err  = (drv_lat == 0);
                exp_q.push_back(e);
                lat_q.push_back(drv_lat);
            end
            if (bus.out_valid && bus.out_ready) begin
                last_out_acc = 1'b1;
                last_prodt   = bus.out_prodt;
                last_tag     = bus.out_tag;
                last_err     = bus.out_err;
                chk("result_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("model_prod", bus.out_prodt, e.prod);
                    chk("model_tag", 64'(bus.out_tag), 64'(e.tag));
                    chk("model_err", 64'(bus.out_err), 64'(e.err));
                end
            end
            bus.mul_valid = 1'b0;
            if (bus.mul_start) begin
                if (st_cnt == 0) begin
                    cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
                    if (have_prev) chk("start_low_gap", 64'(low_cnt >= 2), 64'd1);
                    have_prev = 1'b1;
                end
                st_cnt++;
                start_len = st_cnt;
                low_cnt   = 0;
                if (!st_done && cur_lat != 0 && st_cnt == cur_lat) begin
                    bus.mul_valid = 1'b1;
                    bus.mul_prodt = smul(bus.mul_mlier, bus.mul_mcand);
                    st_done = 1'b1;
                end
            end else begin
                st_cnt = 0;
                st_done = 1'b0;
                low_cnt++;
                if (spurious && $urandom_range(0, 3) == 0) begin
                    bus.mul_valid = 1'b1;
                    bus.mul_prodt = {$urandom(), $urandom()};
                end
            end
        end
        @(posedge clock);
        #1;
        if (rand_ready) bus.out_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic push(input logic [31:0] m, input logic [31:0] c,
                        input logic [TAG_W-1:0] t, input int lat);
        bit got = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_mlier = m;
        bus.in_mcand = c;
        bus.in_tag   = t;
        drv_lat      = lat;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (last_in_acc) begin
                got = 1'b1;
                break;
            end
        end
        bus.in_valid = 1'b0;
        chk("push_accepted", 64'(got), 64'd1);
    endtask

    task automatic wait_out(input int bound);
        bit got = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (last_out_acc) begin
                got = 1'b1;
                break;
            end
        end
        chk("result_arrived", 64'(got), 64'd1);
    endtask

    task automatic drain(input int bound);
        bit ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (exp_q.size() == 0 && !bus.busy && !bus.out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drained", 64'(ok), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        bit any_acc;
        vecs[0] = '{32'd3,          32'd5,          4'd1,  4,       64'd15,                  1'b0};
        vecs[1] = '{32'hFFFF_FFF9,  32'd6,          4'd2,  1,       64'hFFFF_FFFF_FFFF_FFD6, 1'b0};
        vecs[2] = '{32'h8000_0000,  32'd1,          4'd3,  7,       64'hFFFF_FFFF_8000_0000, 1'b0};
        vecs[3] = '{32'h7FFF_FFFF,  32'h7FFF_FFFF,  4'd4,  2,       64'h3FFF_FFFF_0000_0001, 1'b0};
        vecs[4] = '{32'h8000_0000,  32'h8000_0000,  4'd5,  3,       64'h4000_0000_0000_0000, 1'b0};
        vecs[5] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  4'd6,  5,       64'd1,                   1'b0};
        vecs[6] = '{32'h0000_1234,  32'h0000_0010,  4'd7,  0,       64'd0,                   1'b1};
        vecs[7] = '{32'h0000_1234,  32'h0000_0010,  4'd8,  1,       64'h0000_0000_0001_2340, 1'b0};
        vecs[8] = '{32'hFFFF_FFFE,  32'd3,          4'd9,  TIMEOUT, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0};
        vecs[9] = '{32'd0,          32'hDEAD_BEEF,  4'd10, 2,       64'd0,                   1'b0};

        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_mlier  = 32'd0;
        bus.in_mcand  = 32'd0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        bus.mul_valid = 1'b0;
        bus.mul_prodt = 64'd0;
        repeat (2) tick();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_prodt", bus.out_prodt, 64'd0);
        chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
        chk("rst_out_err", 64'(bus.out_err), 64'd0);
        chk("rst_mul_start", 64'(bus.mul_start), 64'd0);
        chk("rst_mul_mlier", 64'(bus.mul_mlier), 64'd0);
        chk("rst_mul_mcand", 64'(bus.mul_mcand), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        reset_n = 1'b1;
        tick();

        // Directed vectors: single op, signed cases, timeout, recovery, collision.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(vecs[i].mlier, vecs[i].mcand, vecs[i].tag, vecs[i].lat);
            if (i == 0) begin
                chk("start_not_yet", 64'(bus.mul_start), 64'd0);
                tick();
                chk("start_after_pop", 64'(bus.mul_start), 64'd1);
                chk("busy_in_issue", 64'(bus.busy), 64'd1);
            end
            wait_out(TIMEOUT + 60);
            chk("vec_prod", last_prodt, vecs[i].prod);
            chk("vec_tag", 64'(last_tag), 64'(vecs[i].tag));
            chk("vec_err", 64'(last_err), 64'(vecs[i].err));
            chk("vec_start_len", 64'(start_len), 64'((vecs[i].lat == 0) ? TIMEOUT : vecs[i].lat));
            chk("vec_out_valid_pulse", 64'(bus.out_valid), 64'd0);
            chk("vec_busy_end", 64'(bus.busy), 64'd0);
        end

        // Back-pressure: one op parked in HOLD, four queued, sixth must wait.
        bus.out_ready = 1'b0;
        for (int t = 0; t < 5; t++) begin
            push(32'(t * 1000 + 7), 32'hFFFF_FF00 + 32'(t), TAG_W'(t), 1 + (t % 3));
            if (t == 3) chk("bp_ready_before_full", 64'(bus.in_ready), 64'd1);
        end
        chk("bp_ready_full", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b1;
        bus.in_mlier = 32'h0001_0000;
        bus.in_mcand = 32'h0001_0000;
        bus.in_tag   = TAG_W'(5);
        drv_lat      = 2;
        any_acc      = 1'b0;
        repeat (5) begin
            tick();
            any_acc |= last_in_acc;
        end
        chk("bp_sixth_waits", 64'(any_acc), 64'd0);
        bus.out_ready = 1'b1;
        any_acc = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (last_in_acc) begin
                any_acc = 1'b1;
                break;
            end
        end
        bus.in_valid = 1'b0;
        chk("bp_sixth_accepted", 64'(any_acc), 64'd1);
        drain(500);

        // Reset while the multiplier is stuck in ISSUE.
        push(32'd5, 32'd5, TAG_W'(12), 0);
        repeat (3) tick();
        chk("mid_start_high", 64'(bus.mul_start), 64'd1);
        reset_n = 1'b0;
        #2;
        chk("async_rst_start", 64'(bus.mul_start), 64'd0);
        chk("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("async_rst_busy", 64'(bus.busy), 64'd0);
        chk("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        push(32'd2, 32'd2, TAG_W'(13), 3);
        wait_out(100);
        chk("post_rst_prod", last_prodt, 64'd4);
        chk("post_rst_tag", 64'(last_tag), 64'd13);

        // Randomized traffic with random back-pressure and stray mul_valid pulses.
        rand_ready = 1'b1;
        spurious   = 1'b1;
        for (int i = 0; i < 40; i++) begin
            push($urandom(), $urandom(), TAG_W'(i), $urandom_range(1, 8));
            repeat ($urandom_range(0, 2)) tick();
        end
        rand_ready    = 1'b0;
        bus.out_ready = 1'b1;
        drain(1000);
        spurious = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mul_issue_ctrl.md
# mul_issue_ctrl

Upstream issue controller for the variable-latency 32x32 signed multiplier `multi_vl`. It buffers operand pairs from a valid/ready producer in a small FIFO. It drives the multiplier's level-held `start` protocol, including the mandatory low gap between operations, and captures each product on the multiplier's one-cycle `valid` pulse. Results go to a valid/ready consumer with a tag, and a watchdog flags operations that never complete.

## Interface
- DEPTH, 4: input FIFO entries; power of 2, ≥2.
- TIMEOUT, 40: max cycles in ISSUE without `mul_valid` before abort.
- TAG_W, 4: width of the pass-through tag.
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer has an operand pair.
- in_ready  out  1  FIFO can accept; equals !full.
- in_mlier  in  32  signed multiplier operand.
- in_mcand  in  32  signed multiplicand operand.
- in_tag  in  TAG_W  request tag.
- out_valid  out  1  result held for consumer.
- out_ready  in  1  consumer accepts.
- out_prodt  out  64  signed product.
- out_tag  out  TAG_W  tag of the result.
- out_err  out  1  result aborted by watchdog; `out_prodt` = 0.
- mul_mlier  out  32  to `multi_vl.mlier`, registered.
- mul_mcand  out  32  to `multi_vl.mcand`, registered.
- mul_start  out  1  to `multi_vl.start`, registered.
- mul_prodt  in  64  from `multi_vl.prodt`.
- mul_valid  in  1  from `multi_vl.valid`, 1-cycle pulse.
- busy  out  1  FIFO non-empty or state ≠ IDLE.

## Operation
- FIFO
  - Circular buffer; each entry holds {mlier, mcand, tag}.
  - Pointers are log2(DEPTH)+1 bits wide; full/empty come from MSB compare.
  - Push on `in_valid & in_ready`.
  - When full, `in_ready` = 0 even if a pop happens the same cycle; no bypass.
  - Simultaneous push and pop at non-full/non-empty: both occur, count unchanged.
- FSM states: IDLE, ISSUE, HOLD.
  - IDLE → ISSUE when FIFO non-empty. Pop the head into `mul_mlier`/`mul_mcand`/tag register, set `mul_start` = 1, clear the watchdog.
  - ISSUE: `mul_start` = 1 and operands stay constant. The watchdog increments each cycle.
    - On `mul_valid` = 1: capture `mul_prodt` into `out_prodt`, set `out_err` = 0, `out_valid` = 1, `mul_start` = 0. Go to HOLD.
    - Else, when the watchdog reaches TIMEOUT−1: set `out_prodt` = 0, `out_err` = 1, `out_valid` = 1, `mul_start` = 0. Go to HOLD.
    - `mul_valid` takes priority over the timeout in the same cycle.
  - HOLD: `mul_start` = 0. On `out_valid & out_ready`, clear `out_valid` and go to IDLE.
- HOLD plus IDLE guarantee `mul_start` is low for at least 2 cycles between operations, which re-initialises `multi_vl`.
- `mul_valid` outside ISSUE is ignored.
- Results leave in FIFO order. At most one op is in flight.
- No arithmetic here; the product is passed through unmodified as 64-bit two's complement.

## Timing
- Reset: `in_ready` = 1, `out_valid` = 0, `out_prodt` = 0, `out_tag` = 0, `out_err` = 0, `mul_start` = 0, `mul_mlier` = 0, `mul_mcand` = 0, `busy` = 0. FIFO is emptied, state = IDLE, watchdog = 0.
- Reset asserted mid-operation clears everything immediately. `mul_start` drops asynchronously and the in-flight result is lost.
- Push at edge N: entry visible at N+1, `mul_start` high from N+2.
- `mul_valid` sampled at edge M: `out_valid` high from M+1.
- Accept at edge K (`out_valid & out_ready`):
  - state = IDLE after K;
  - next `mul_start` high after K+1 if the FIFO is non-empty.
- Outputs are registered; no combinational path from `in_*` or `out_ready` to any output except `in_ready` (from FIFO state only).

## Test plan
- Single op: push mlier=3, mcand=5, tag=1 with `out_ready`=1 → one `out_valid` pulse; `out_prodt`=15, `out_tag`=1, `out_err`=0; `busy` ends at 0.
- Signed: push −7 × 6 → `out_prodt`=0xFFFFFFFFFFFFFFD6. Then push 0x80000000 × 1 → 0xFFFFFFFF80000000.
- Back-pressure:
  - Hold `out_ready`=0 and push 6 ops tagged 0..5. The first is popped into ISSUE, so `in_ready` falls after the 5th push; the 6th waits.
  - Release `out_ready` → tags 0..5 emerge in order with correct products.
  - `mul_start` is low ≥2 cycles between ops.
- Timeout: stub `mul_valid` stuck at 0 → `out_valid` after TIMEOUT cycles of ISSUE with `out_err`=1, `out_prodt`=0. The next op proceeds normally.
- Collision: stub drives `mul_valid` exactly in the TIMEOUT−1 cycle → `out_err`=0, product captured.
- Reset mid-ISSUE: assert `reset_n`=0 while `mul_start`=1 → `mul_start`, `out_valid`, `busy` = 0 without waiting for a clock edge. After release, a new push of 2×2 returns 4.
